stream_fifo_chan: RTL and testbench
===================================

// Module: stream_fifo_chan
// PURPOSE
//   FIFO channel between two stream cells of the insertion-sort dataflow chain.
//   Acts as the other end of a cell's stream ports:
//   - write side serves a producer's out_V_din/out_V_full_n/out_V_write;
//   - read side serves a consumer's in_V_dout/in_V_empty_n/in_V_read.
//   Read side is first-word-fall-through: the head word is on dout whenever
//   empty_n=1, so a consumer may compare and pop it in the same cycle.
// PARAMETERS
//   DATA_WIDTH  32  width of stored words (signed data, passed through untouched)
//   DEPTH       2   number of entries; legal range 2..256
//   ADDR_WIDTH  1   pointer width = clog2(DEPTH); count is ADDR_WIDTH+1 bits
// PORTS
//   ap_clk     in   1             clock, rising edge
//   ap_rst     in   1             asynchronous reset, active-high
//   din        in   DATA_WIDTH    write data from producer
//   full_n     out  1             1 = space available
//   write      in   1             producer push request
//   dout       out  DATA_WIDTH    head word (valid when empty_n=1)
//   empty_n    out  1             1 = at least one word stored
//   read       in   1             consumer pop request
//   count      out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   ovf_err    out  1             sticky: write attempted while full_n=0
//   udf_err    out  1             sticky: read attempted while empty_n=0
// BEHAVIOUR
//   Reset (ap_rst=1, async):
//   - wptr, rptr and count = 0; every mem entry = 0;
//     ovf_err = udf_err = 0; full_n = 1; empty_n = 0; dout = 0.
//   Storage:
//   - circular buffer mem[DEPTH], write pointer wptr, read pointer rptr;
//   - each pointer wraps from DEPTH-1 to 0, including non-power-of-2 DEPTH.
//   Handshake acceptance:
//   - push = write & full_n; pop = read & empty_n.
//   - A request without its qualifier is ignored: no state change, except the
//     sticky error flag.
//   Flags:
//   - full_n  = (count != DEPTH); empty_n = (count != 0).
//   - Both come from registered state only; no combinational path from
//     write/read to full_n/empty_n.
//   - dout = mem[rptr], combinational from registered state only.
//   Clocked update:
//   - push only: mem[wptr] <= din; wptr++; count++.
//   - pop only: rptr++; count--.
//   - push and pop together: both pointers advance; count unchanged.
//   Latency:
//   - A word pushed at edge N is on dout with empty_n=1 after edge N (visible
//     in cycle N+1). No bypass from din to dout when empty.
//   - Pop at edge N shows the next word (or empty_n=0) in cycle N+1.
//   Boundaries:
//   - Full, with read and write both high: pop accepted, push rejected
//     (full_n=0 that cycle), ovf_err set. full_n returns to 1 next cycle.
//   - Empty, with read and write both high: push accepted, pop ignored,
//     udf_err set. empty_n becomes 1 next cycle.
//   - Flags are recomputed from count every cycle, so a DEPTH=2 channel
//     sustains 1 word/cycle when producer and consumer both stream.
//   Error flags:
//   - ovf_err and udf_err clear only on ap_rst.
//   Reset mid-operation:
//   - Contents are discarded; outputs take reset values asynchronously, with no
//     wait for a clock edge.
// TESTING
//   1. Reset, then idle: full_n=1, empty_n=0, count=0, dout=0, err flags 0.
//   2. DEPTH=2:
//      - push 0x00000005: next cycle dout=5, empty_n=1, count=1;
//      - push 0xFFFFFFFD: count=2, full_n=0, dout still 5.
//   3. Full and both read/write high with din=7:
//      - dout=5 popped, 7 not stored, ovf_err=1;
//      - next cycle dout=0xFFFFFFFD, count=1.
//   4. Continuous stream of 1..20, write and read high every cycle after first push:
//      - dout order is 1..20; count holds at 1; no flag errors.
//   5. DEPTH=3 wrap: 10 pushes interleaved with pops -> FIFO order kept across
//      pointer wrap at 2->0.
//   6. Assert ap_rst asynchronously with count=2 -> same cycle empty_n=0,
//      full_n=1, count=0; next push shows the new word, not stale data.

Source files
------------

// File: rtl/stream_fifo_chan_if.sv
// Stream channel bundle: producer write side and consumer read side of one
// FIFO channel, plus occupancy and sticky error status.
interface stream_fifo_chan_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] din;
  logic                  full_n;
  logic                  write;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty_n;
  logic                  read;
  logic [ADDR_WIDTH:0]   count;
  logic                  ovf_err;
  logic                  udf_err;

  // Producer/consumer side driving the channel.
  modport master (
    output din, write, read,
    input  full_n, dout, empty_n, count, ovf_err, udf_err
  );

  // The FIFO itself.
  modport slave (
    input  din, write, read,
    output full_n, dout, empty_n, count, ovf_err, udf_err
  );
endinterface

// File: rtl/stream_fifo_chan.sv
// FIFO channel between two stream cells. Circular buffer with
// first-word-fall-through read side; flags derive from the registered count
// only, so neither write nor read has a combinational path to full_n/empty_n.
module stream_fifo_chan #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  stream_fifo_chan_if.slave ch
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full_n, empty_n, push, pop;

  // Wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + PTR_ONE;
  endfunction

  assign full_n  = (count_q != CNT_FULL);
  assign empty_n = (count_q != '0);
  assign push    = ch.write & full_n;
  assign pop     = ch.read & empty_n;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (ch.write & ~full_n);
    udf_d   = udf_q | (ch.read & ~empty_n);
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards everything immediately.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage; cleared on reset so dout reads 0 rather than stale data.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= ch.din;
    end
  end

  assign ch.full_n  = full_n;
  assign ch.empty_n = empty_n;
  assign ch.dout    = mem_q[rptr_q];
  assign ch.count   = count_q;
  assign ch.ovf_err = ovf_q;
  assign ch.udf_err = udf_q;

endmodule

// File: tb/tb_stream_fifo_chan.sv
// Bench for stream_fifo_chan: vector table on a DEPTH=2 channel, scoreboard
// streaming on DEPTH=2 and DEPTH=3 channels, async reset mid-operation.
module tb_stream_fifo_chan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_fifo_chan_if #(.DATA_WIDTH(32), .ADDR_WIDTH(1)) cha ();
  stream_fifo_chan_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) chb ();

  stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(2), .ADDR_WIDTH(1)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .ch(cha)
  );
  stream_fifo_chan #(.DATA_WIDTH(32), .DEPTH(3), .ADDR_WIDTH(2)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .ch(chb)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] din;
    logic        full_n;
    logic        empty_n;
    logic [31:0] count;
    logic        chk_dout;
    logic [31:0] dout;
    logic        ovf;
    logic        udf;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle on channel A (sel=0) or B (sel=1). Requests are gated by the
  // flags sampled this cycle; the scoreboard follows the accepted handshakes.
  task automatic cycle(input bit sel, input bit w, input bit r, input logic [31:0] d,
                       output bit acc_w, output bit acc_r, output logic [31:0] cnt);
    logic fn, en;
    logic [31:0] dt;
    @(posedge clk); #1;
    fn  = sel ? chb.full_n  : cha.full_n;
    en  = sel ? chb.empty_n : cha.empty_n;
    dt  = sel ? chb.dout    : cha.dout;
    cnt = sel ? 32'(chb.count) : 32'(cha.count);
    acc_w = w & fn;
    acc_r = r & en;
    cha.write = sel ? 1'b0 : acc_w;
    cha.read  = sel ? 1'b0 : acc_r;
    cha.din   = d;
    chb.write = sel ? acc_w : 1'b0;
    chb.read  = sel ? acc_r : 1'b0;
    chb.din   = d;
    if (acc_w) sb.push_back(d);
    if (acc_r) begin
      pops++;
      if (sb.size() == 0) check("sb_underrun", 32'd1, 32'd0);
      else check("stream_dout", dt, sb.pop_front());
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cha.write = 1'b0; cha.read = 1'b0;
    chb.write = 1'b0; chb.read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    bit aw, ar;
    logic [31:0] cnt;
    int pushed, budget;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b1, 32'd1, 1'b1, 32'h0000_0005, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'd2, 1'b1, 32'h0000_0005, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b1, 32'd1, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0009, 1'b1, 1'b1, 32'd1, 1'b1, 32'h0000_0009, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_000A, 1'b1, 1'b1, 32'd1, 1'b1, 32'h0000_000A, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'd1, 1'b1, 32'h0000_000A, 1'b1, 1'b1};

    cha.write = 1'b0; cha.read = 1'b0; cha.din = '0;
    chb.write = 1'b0; chb.read = 1'b0; chb.din = '0;

    // Reset values, sampled while reset is held.
    #12;
    check("rst_full_n",  32'(cha.full_n),  32'd1);
    check("rst_empty_n", 32'(cha.empty_n), 32'd0);
    check("rst_count",   32'(cha.count),   32'd0);
    check("rst_dout",    cha.dout,         32'd0);
    check("rst_ovf",     32'(cha.ovf_err), 32'd0);
    check("rst_udf",     32'(cha.udf_err), 32'd0);
    rst = 1'b0;

    // Vector table on DEPTH=2: fill, full with read+write, drain, empty with read+write.
    for (int i = 0; i < 8; i++) begin
      cha.write = vecs[i].w;
      cha.read  = vecs[i].r;
      cha.din   = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("v%0d_full_n", i),  32'(cha.full_n),  32'(vecs[i].full_n));
      check($sformatf("v%0d_empty_n", i), 32'(cha.empty_n), 32'(vecs[i].empty_n));
      check($sformatf("v%0d_count", i),   32'(cha.count),   vecs[i].count);
      if (vecs[i].chk_dout) check($sformatf("v%0d_dout", i), cha.dout, vecs[i].dout);
      check($sformatf("v%0d_ovf", i),     32'(cha.ovf_err), 32'(vecs[i].ovf));
      check($sformatf("v%0d_udf", i),     32'(cha.udf_err), 32'(vecs[i].udf));
    end
    cha.write = 1'b0; cha.read = 1'b0;

    // Continuous stream 1..20 on DEPTH=2; occupancy must stay at 1.
    rst = 1'b1; #2; rst = 1'b0;
    sb.delete(); pops = 0;
    cycle(1'b0, 1'b1, 1'b0, 32'd1, aw, ar, cnt);
    for (int k = 2; k <= 20; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'(k), aw, ar, cnt);
      check("stream_count", cnt, 32'd1);
    end
    budget = 5;
    while (pops < 20 && budget > 0) begin
      cycle(1'b0, 1'b0, 1'b1, 32'd0, aw, ar, cnt);
      budget--;
    end
    idle();
    check("stream_pops",    32'(pops),        32'd20);
    check("stream_empty_n", 32'(cha.empty_n), 32'd0);
    check("stream_ovf",     32'(cha.ovf_err), 32'd0);
    check("stream_udf",     32'(cha.udf_err), 32'd0);

    // DEPTH=3: 10 pushes with random interleaved pops, crossing the 2->0 wrap.
    sb.delete(); pops = 0; pushed = 0; budget = 300;
    while (pushed < 10 && budget > 0) begin
      cycle(1'b1, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
            32'(100 + pushed), aw, ar, cnt);
      if (aw) pushed++;
      budget--;
    end
    budget = 10;
    while (pops < 10 && budget > 0) begin
      cycle(1'b1, 1'b0, 1'b1, 32'd0, aw, ar, cnt);
      budget--;
    end
    idle();
    check("wrap_pushed", 32'(pushed),      32'd10);
    check("wrap_pops",   32'(pops),        32'd10);
    check("wrap_count",  32'(chb.count),   32'd0);
    check("wrap_ovf",    32'(chb.ovf_err), 32'd0);
    check("wrap_udf",    32'(chb.udf_err), 32'd0);

    // Async reset with two words stored; flags must drop without a clock edge.
    sb.delete(); pops = 0;
    cycle(1'b0, 1'b1, 1'b0, 32'h1111_1111, aw, ar, cnt);
    cycle(1'b0, 1'b1, 1'b0, 32'h2222_2222, aw, ar, cnt);
    idle();
    check("pre_rst_count", 32'(cha.count), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_empty_n", 32'(cha.empty_n), 32'd0);
    check("async_rst_full_n",  32'(cha.full_n),  32'd1);
    check("async_rst_count",   32'(cha.count),   32'd0);
    #1;
    rst = 1'b0;
    cha.write = 1'b1; cha.din = 32'h0000_0055;
    @(posedge clk); #1;
    cha.write = 1'b0;
    check("post_rst_dout",  cha.dout,         32'h0000_0055);
    check("post_rst_count", 32'(cha.count),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
